// File: rtl/frame_packetizer.sv
// Frame packetizer: buffers header/pixel words of each accepted frame in a FWFT FIFO and
// closes every captured frame with a footer word {flags[3:0], wcount[27:0]}.
module frame_packetizer #(
  parameter int ADDR_WIDTH        = 9,
  parameter int HEADROOM          = 64,
  parameter int DTYPE_WIDTH       = 4,
  parameter logic [DTYPE_WIDTH-1:0] DTYPE_FRAME_START = 4'h1,
  parameter logic [DTYPE_WIDTH-1:0] DTYPE_FRAME_END   = 4'h2,
  parameter logic [DTYPE_WIDTH-1:0] DTYPE_HEADER      = 4'h3,
  parameter logic [DTYPE_WIDTH-1:0] DTYPE_PIXEL_MASK  = 4'hC
) (
  input  logic                   clk,
  input  logic                   resetb,
  input  logic                   enable,
  input  logic                   dvi,
  input  logic [DTYPE_WIDTH-1:0] dtypei,
  input  logic [31:0]            datai,
  output logic                   dout_valid,
  input  logic                   dout_ready,
  output logic [31:0]            dout,
  output logic                   dout_last,
  output logic [15:0]            frame_count,
  output logic [15:0]            drop_count,
  output logic [ADDR_WIDTH:0]    fill_level
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_V = DEPTH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] HEADROOM_V = HEADROOM[ADDR_WIDTH:0];

  typedef enum logic [1:0] {IDLE, CAPTURE, DROP} state_t;

  state_t                state_q, state_d;
  logic [27:0]           wcount_q, wcount_d;
  logic [3:0]            flags_q, flags_d;
  logic [15:0]           frame_cnt_q, frame_cnt_d;
  logic [15:0]           drop_cnt_q, drop_cnt_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   fill_q, fill_d;
  logic [32:0]           mem_q [DEPTH];

  logic                  is_start, is_end, is_payload, start_dec;
  logic                  wr_en, wr_go, wr_last, rd_go;
  logic [31:0]           wr_data;
  logic [ADDR_WIDTH:0]   free, start_free;

  assign is_start   = dvi && (dtypei == DTYPE_FRAME_START);
  assign is_end     = dvi && (dtypei == DTYPE_FRAME_END);
  assign is_payload = dvi && (((dtypei & DTYPE_PIXEL_MASK) != '0) || (dtypei == DTYPE_HEADER));
  assign free       = DEPTH_V - fill_q;

  always_comb begin
    state_d     = state_q;
    wcount_d    = wcount_q;
    flags_d     = flags_q;
    frame_cnt_d = frame_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    wr_en       = 1'b0;
    wr_last     = 1'b0;
    wr_data     = '0;
    start_dec   = 1'b0;
    start_free  = free;
    case (state_q)
      IDLE: start_dec = is_start;
      CAPTURE: begin
        if (is_end) begin
          wr_en       = 1'b1;
          wr_last     = 1'b1;
          wr_data     = {flags_q, wcount_q};
          frame_cnt_d = frame_cnt_q + 16'd1;
          state_d     = IDLE;
        end else if (is_start) begin
          // Missing FRAME_END: close the old frame, then judge the new one with the footer slot gone
          wr_en       = 1'b1;
          wr_last     = 1'b1;
          wr_data     = {flags_q | 4'b0010, wcount_q};
          frame_cnt_d = frame_cnt_q + 16'd1;
          start_dec   = 1'b1;
          start_free  = free - 1'b1;
        end else if (is_payload) begin
          if (free > 1) begin
            wr_en   = 1'b1;
            wr_data = datai;
            if (wcount_q != '1) wcount_d = wcount_q + 28'd1;
          end else begin
            flags_d[0] = 1'b1;
          end
        end
      end
      DROP: if (is_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (start_dec) begin
      if (enable && (start_free >= HEADROOM_V)) begin
        state_d  = CAPTURE;
        wcount_d = '0;
        flags_d  = '0;
      end else begin
        state_d    = DROP;
        drop_cnt_d = drop_cnt_q + 16'd1;
      end
    end
  end

  assign wr_go    = wr_en && (free != '0);
  assign rd_go    = dout_valid && dout_ready;
  assign wr_ptr_d = wr_go ? wr_ptr_q + 1'b1 : wr_ptr_q;
  assign rd_ptr_d = rd_go ? rd_ptr_q + 1'b1 : rd_ptr_q;

  always_comb begin
    fill_d = fill_q;
    if (wr_go && !rd_go) fill_d = fill_q + 1'b1;
    else if (!wr_go && rd_go) fill_d = fill_q - 1'b1;
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q     <= IDLE;
      wcount_q    <= '0;
      flags_q     <= '0;
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fill_q      <= '0;
    end else begin
      state_q     <= state_d;
      wcount_q    <= wcount_d;
      flags_q     <= flags_d;
      frame_cnt_q <= frame_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fill_q      <= fill_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_go) mem_q[wr_ptr_q] <= {wr_last, wr_data};
  end

  // Storage is not reset, so the data outputs are gated to read 0 while empty
  assign dout_valid  = (fill_q != '0);
  assign dout        = dout_valid ? mem_q[rd_ptr_q][31:0] : '0;
  assign dout_last   = dout_valid & mem_q[rd_ptr_q][32];
  assign frame_count = frame_cnt_q;
  assign drop_count  = drop_cnt_q;
  assign fill_level  = fill_q;
endmodule

// File: tb/tb_frame_packetizer.sv
// Directed bench for frame_packetizer with a 16-word FIFO and headroom of 4.
module tb_frame_packetizer;
  localparam logic [3:0] FS = 4'h1, FE = 4'h2, PIX = 4'h4;

  logic        clk = 1'b0;
  logic        resetb = 1'b0;
  logic        enable = 1'b1;
  logic        dvi = 1'b0;
  logic [3:0]  dtypei = '0;
  logic [31:0] datai = '0;
  logic        dout_valid, dout_ready, dout_last;
  logic [31:0] dout;
  logic [15:0] frame_count, drop_count;
  logic [4:0]  fill_level;

  int total = 0;
  int bad = 0;
  logic        toggle_rdy = 1'b0;
  logic [32:0] q[$];
  logic        stalled = 1'b0;
  logic [32:0] held = '0;

  frame_packetizer #(.ADDR_WIDTH(4), .HEADROOM(4)) dut (
    .clk(clk), .resetb(resetb), .enable(enable), .dvi(dvi), .dtypei(dtypei), .datai(datai),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .dout(dout), .dout_last(dout_last),
    .frame_count(frame_count), .drop_count(drop_count), .fill_level(fill_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [32:0] qa(input int i);
    return (i < q.size()) ? q[i] : 33'bx;
  endfunction

  // Accepted words are collected here; a stalled word must not change until taken
  always @(negedge clk) begin
    if (!resetb) stalled = 1'b0;
    else begin
      if (stalled) chk("stable", {dout_valid, dout_last, dout}, {1'b1, held});
      if (dout_valid && dout_ready) q.push_back({dout_last, dout});
      stalled = dout_valid && !dout_ready;
      held    = {dout_last, dout};
    end
  end

  task automatic drive(input logic dv, input logic [3:0] dt, input logic [31:0] d);
    @(posedge clk); #2;
    if (toggle_rdy) dout_ready = ~dout_ready;
    dvi = dv; dtypei = dt; datai = d;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 4'h0, 32'h0);
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    resetb = 1'b0; dvi = 1'b0;
    @(posedge clk); #2;
    resetb = 1'b1;
    q.delete();
  endtask

  initial begin
    dout_ready = 1'b1;
    #12 resetb = 1'b1;
    @(negedge clk);
    chk("rst_valid", dout_valid, 0);
    chk("rst_dout", {dout_last, dout}, 0);
    chk("rst_fill", fill_level, 0);
    chk("rst_counts", {frame_count, drop_count}, 0);

    // 1: single 10-word frame straight through
    drive(1, FS, 0);
    for (int i = 0; i < 10; i++) drive(1, PIX, i);
    drive(1, FE, 0);
    idle(5);
    chk("t1_size", q.size(), 11);
    for (int i = 0; i < 10; i++) chk("t1_word", qa(i), {1'b0, 32'(i)});
    chk("t1_footer", qa(10), {1'b1, 32'h0000000A});
    chk("t1_frames", frame_count, 1);

    // 2: overflow with output blocked
    do_reset();
    dout_ready = 1'b0;
    drive(1, FS, 0);
    for (int i = 0; i < 20; i++) drive(1, PIX, 100 + i);
    drive(1, FE, 0);
    idle(2);
    chk("t2_fill", fill_level, 16);
    chk("t2_none_out", q.size(), 0);
    dout_ready = 1'b1;
    idle(20);
    chk("t2_size", q.size(), 16);
    for (int i = 0; i < 15; i++) chk("t2_word", qa(i), {1'b0, 32'(100 + i)});
    chk("t2_footer", qa(15), {1'b1, 32'h1000000F});
    chk("t2_drained", fill_level, 0);

    // 3: frame dropped for lack of headroom
    do_reset();
    dout_ready = 1'b0;
    drive(1, FS, 0);
    for (int i = 0; i < 12; i++) drive(1, PIX, 200 + i);
    drive(1, FE, 0);
    idle(2);
    chk("t3_fill13", fill_level, 13);
    drive(1, FS, 0);
    drive(1, PIX, 32'hDEAD);
    drive(1, PIX, 32'hDEAD);
    drive(1, FE, 0);
    idle(2);
    chk("t3_drops", drop_count, 1);
    chk("t3_fill_same", fill_level, 13);
    dout_ready = 1'b1;
    idle(20);
    chk("t3_size", q.size(), 13);
    for (int i = 0; i < 12; i++) chk("t3_word", qa(i), {1'b0, 32'(200 + i)});
    chk("t3_footer", qa(12), {1'b1, 32'h0000000C});
    chk("t3_frames", frame_count, 1);

    // 4: missing FRAME_END closes the first frame with flags[1]
    do_reset();
    drive(1, FS, 0);
    for (int i = 1; i <= 3; i++) drive(1, PIX, i);
    drive(1, FS, 0);
    drive(1, PIX, 4);
    drive(1, PIX, 5);
    drive(1, FE, 0);
    idle(5);
    chk("t4_size", q.size(), 7);
    for (int i = 0; i < 3; i++) chk("t4_a", qa(i), {1'b0, 32'(i + 1)});
    chk("t4_footer_a", qa(3), {1'b1, 32'h20000003});
    chk("t4_b0", qa(4), {1'b0, 32'd4});
    chk("t4_b1", qa(5), {1'b0, 32'd5});
    chk("t4_footer_b", qa(6), {1'b1, 32'h00000002});
    chk("t4_frames", frame_count, 2);
    chk("t4_drops", drop_count, 0);

    // 5: ready toggling every cycle
    do_reset();
    toggle_rdy = 1'b1;
    drive(1, FS, 0);
    for (int i = 0; i < 8; i++) drive(1, PIX, 32'h50 + i);
    drive(1, FE, 0);
    idle(30);
    toggle_rdy = 1'b0;
    dout_ready = 1'b1;
    chk("t5_size", q.size(), 9);
    for (int i = 0; i < 8; i++) chk("t5_word", qa(i), {1'b0, 32'(32'h50 + i)});
    chk("t5_footer", qa(8), {1'b1, 32'h00000008});

    // 6: reset in the middle of a captured frame
    do_reset();
    dout_ready = 1'b0;
    drive(1, FS, 0);
    drive(1, PIX, 32'h77);
    drive(1, FE, 0);
    drive(1, FS, 0);
    for (int i = 0; i < 3; i++) drive(1, PIX, i);
    idle(1);
    chk("t6_pre_fill", fill_level, 5);
    chk("t6_pre_frames", frame_count, 1);
    @(posedge clk); #2;
    resetb = 1'b0; dvi = 1'b0;
    @(posedge clk); #2;
    chk("t6_valid", dout_valid, 0);
    chk("t6_fill", fill_level, 0);
    chk("t6_counts", {frame_count, drop_count}, 0);
    resetb = 1'b1;
    idle(2);
    chk("t6_after_valid", dout_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
